// File: rtl/mc_control_unit_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states,
// datapath select codes and the per-state control word.
package mc_control_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_R_EXEC  = 4'd6,
        S_ALU_WB  = 4'd7,
        S_BRANCH  = 4'd8,
        S_I_EXEC  = 4'd9,
        S_I_WB    = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       is_store;
        logic       half;
        logic       half_unsigned;
        logic [2:0] imm_op;
    } op_class_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    // Moore control word for a state; the fetch-complete strobes are added by the top.
    function automatic ctrl_t ctrl_for_state(input state_t s, input logic [2:0] imm_op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:   begin c.mem_read = 1'b1; c.alu_src_b = SRCB_FOUR; c.pc_src = PC_ALU; end
            S_DECODE:  c.alu_src_b = SRCB_IMM_SL2;
            S_MEM_ADR: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; end
            S_MEM_RD:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
            S_MEM_WB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            S_MEM_WR:  begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
            S_R_EXEC:  begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_REG; c.alu_op = ALU_FUNCT; end
            S_ALU_WB:  begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            S_BRANCH:  begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_src        = PC_ALUOUT;
            end
            S_I_EXEC:  begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.alu_op = imm_op; end
            S_I_WB:    c.reg_write = 1'b1;
            S_JUMP:    begin c.pc_write = 1'b1; c.pc_src = PC_JUMP; end
            default:   c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_opcode_decode.sv
// Combinational opcode decode: instruction class and the state that follows DECODE.
import mc_control_unit_pkg::*;

module mc_opcode_decode #(
    parameter int ENABLE_HALF = 1,
    parameter int ENABLE_JUMP = 1
) (
    input  logic [5:0] op_code,
    output logic       valid,
    output state_t     next_state,
    output op_class_t  op_class
);

    always_comb begin
        valid      = 1'b1;
        next_state = S_FETCH;
        op_class   = '0;
        case (op_code)
            OP_RTYPE: next_state = S_R_EXEC;
            OP_LW:    next_state = S_MEM_ADR;
            OP_SW:    begin next_state = S_MEM_ADR; op_class.is_store = 1'b1; end
            OP_LH:
                if (ENABLE_HALF != 0) begin
                    next_state     = S_MEM_ADR;
                    op_class.half  = 1'b1;
                end else begin
                    valid = 1'b0;
                end
            OP_LHU:
                if (ENABLE_HALF != 0) begin
                    next_state             = S_MEM_ADR;
                    op_class.half          = 1'b1;
                    op_class.half_unsigned = 1'b1;
                end else begin
                    valid = 1'b0;
                end
            OP_ADDI:  begin next_state = S_I_EXEC; op_class.imm_op = ALU_ADD; end
            OP_ANDI:  begin next_state = S_I_EXEC; op_class.imm_op = ALU_AND; end
            OP_ORI:   begin next_state = S_I_EXEC; op_class.imm_op = ALU_OR;  end
            OP_BEQ:   next_state = S_BRANCH;
            OP_J:
                if (ENABLE_JUMP != 0) next_state = S_JUMP;
                else                  valid = 1'b0;
            default:  valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle processor control FSM. Control word is registered from the next
// state so outputs are a clean function of the current state.
import mc_control_unit_pkg::*;

module mc_control_unit #(
    parameter int ENABLE_HALF = 1,
    parameter int ENABLE_JUMP = 1,
    parameter int MEM_WAIT_EN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op_code,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_src,
    output logic       half,
    output logic       half_unsigned,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t    cur_state;
    state_t    nxt_state;
    state_t    dec_next;
    op_class_t dec_class;
    op_class_t cls_q;
    op_class_t cls_nxt;
    ctrl_t     ctrl_q;
    logic      dec_valid;
    logic      mem_done;
    logic      fetch_done;

    mc_opcode_decode #(
        .ENABLE_HALF (ENABLE_HALF),
        .ENABLE_JUMP (ENABLE_JUMP)
    ) u_decode (
        .op_code    (op_code),
        .valid      (dec_valid),
        .next_state (dec_next),
        .op_class   (dec_class)
    );

    assign mem_done = mem_ready || (MEM_WAIT_EN == 0);

    always_comb begin
        nxt_state = S_FETCH;
        cls_nxt   = cls_q;
        case (cur_state)
            S_FETCH:   nxt_state = mem_done ? S_DECODE : S_FETCH;
            S_DECODE:  begin nxt_state = dec_next; cls_nxt = dec_class; end
            S_MEM_ADR: nxt_state = cls_q.is_store ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  nxt_state = mem_done ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:  nxt_state = mem_done ? S_FETCH : S_MEM_WR;
            S_R_EXEC:  nxt_state = S_ALU_WB;
            S_I_EXEC:  nxt_state = S_I_WB;
            default:   nxt_state = S_FETCH;
        endcase
    end

    // Control word tracks the state being entered, using the class latched alongside it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state <= S_FETCH;
            cls_q     <= '0;
            ctrl_q    <= ctrl_for_state(S_FETCH, ALU_ADD);
        end else begin
            cur_state <= nxt_state;
            cls_q     <= cls_nxt;
            ctrl_q    <= ctrl_for_state(nxt_state, cls_nxt.imm_op);
        end
    end

    // Instruction capture and PC+4 happen only in the cycle the fetch completes.
    assign fetch_done    = (cur_state == S_FETCH) && mem_done;
    assign ir_write      = fetch_done;
    assign pc_write      = ctrl_q.pc_write | fetch_done;
    assign pc_write_cond = ctrl_q.pc_write_cond;
    assign i_or_d        = ctrl_q.i_or_d;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign reg_dst       = ctrl_q.reg_dst;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign reg_write     = ctrl_q.reg_write;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign alu_op        = ctrl_q.alu_op;
    assign pc_src        = ctrl_q.pc_src;
    assign half          = cls_q.half;
    assign half_unsigned = cls_q.half_unsigned;
    assign illegal_op    = rst_n && (cur_state == S_DECODE) && !dec_valid;
    assign state         = cur_state;

endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized self-checking bench for mc_control_unit against an instruction-path model.
module tb_mc_control_unit;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_LH   = 6'b100001;
    localparam logic [5:0] T_LHU  = 6'b100101;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_ANDI = 6'b001100;
    localparam logic [5:0] T_ORI  = 6'b001101;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_J    = 6'b000010;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op_code;
    logic       mem_ready;

    logic       pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_op;
    logic       half, half_unsigned, illegal_op;
    logic [3:0] state;

    logic       pc_write_b, pc_write_cond_b, i_or_d_b, ir_write_b, mem_read_b, mem_write_b;
    logic       reg_dst_b, mem_to_reg_b, reg_write_b, alu_src_a_b;
    logic [1:0] alu_src_b_b, pc_src_b;
    logic [2:0] alu_op_b;
    logic       half_b, half_unsigned_b, illegal_op_b;
    logic [3:0] state_b;

    logic [16:0] obs;
    assign obs = {pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write,
                  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src};

    int          checks = 0;
    int          errors = 0;
    logic        exp_half = 1'b0;
    logic        exp_hu = 1'b0;
    logic [23:0] first_act, first_exp;

    always #5 clk = ~clk;

    mc_control_unit dut (
        .clk(clk), .rst_n(rst_n), .op_code(op_code), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .half(half), .half_unsigned(half_unsigned), .illegal_op(illegal_op), .state(state)
    );

    mc_control_unit #(.ENABLE_HALF(0), .ENABLE_JUMP(0), .MEM_WAIT_EN(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .op_code(op_code), .mem_ready(mem_ready),
        .pc_write(pc_write_b), .pc_write_cond(pc_write_cond_b), .i_or_d(i_or_d_b),
        .ir_write(ir_write_b), .mem_read(mem_read_b), .mem_write(mem_write_b),
        .reg_dst(reg_dst_b), .mem_to_reg(mem_to_reg_b), .reg_write(reg_write_b),
        .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b), .alu_op(alu_op_b), .pc_src(pc_src_b),
        .half(half_b), .half_unsigned(half_unsigned_b), .illegal_op(illegal_op_b), .state(state_b)
    );

    function automatic logic op_illegal(input logic [5:0] op);
        case (op)
            T_R, T_LW, T_SW, T_LH, T_LHU, T_ADDI, T_ANDI, T_ORI, T_BEQ, T_J: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    // Expected control word per state, written straight from the state table.
    function automatic logic [16:0] spec_ctrl(input int st, input logic [5:0] op, input logic mr);
        logic pcw, pcc, iod, irw, mrd, mwr, rdst, m2r, rw, sa;
        logic [1:0] sb, ps;
        logic [2:0] ao;
        {pcw, pcc, iod, irw, mrd, mwr, rdst, m2r, rw, sa} = '0;
        sb = 2'b00; ps = 2'b00; ao = 3'b000;
        case (st)
            0:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mrd = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iod = 1; end
            6:  begin sa = 1; ao = 3'b010; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin sa = 1; ao = 3'b001; pcc = 1; ps = 2'b01; end
            9:  begin sa = 1; sb = 2'b10; ao = (op == T_ORI) ? 3'b100 : (op == T_ANDI) ? 3'b011 : 3'b000; end
            10: rw = 1;
            11: begin pcw = 1; ps = 2'b10; end
            default: ;
        endcase
        return {pcw, pcc, iod, irw, mrd, mwr, rdst, m2r, rw, sa, sb, ao, ps};
    endfunction

    // Runs one instruction from FETCH; waits in FETCH/MEM_RD/MEM_WR whenever mem_ready is low.
    task automatic exec_instr(input logic [5:0] op, input int ready_pct, input int forced,
                              output int cycles, output int bad, output int mw_cyc, output int ill_cyc);
        int path[$];
        int st;
        logic mr, exp_ill;
        logic [16:0] exp;
        case (op)
            T_R:                path = {0, 1, 6, 7};
            T_LW, T_LH, T_LHU:  path = {0, 1, 2, 3, 4};
            T_SW:               path = {0, 1, 2, 5};
            T_ADDI, T_ANDI, T_ORI: path = {0, 1, 9, 10};
            T_BEQ:              path = {0, 1, 8};
            T_J:                path = {0, 1, 11};
            default:            path = {0, 1};
        endcase
        op_code = op;
        cycles = 0; bad = 0; mw_cyc = 0; ill_cyc = 0;
        while (path.size() > 0) begin
            st = path[0];
            if ((st == 3 || st == 5) && forced > 0) begin
                mr = 1'b0;
                forced--;
            end else begin
                mr = ($urandom_range(0, 99) < ready_pct);
            end
            mem_ready = mr;
            #1;
            exp     = spec_ctrl(st, op, mr);
            exp_ill = (st == 1) && op_illegal(op);
            if (state !== st[3:0] || obs !== exp || half !== exp_half || half_unsigned !== exp_hu ||
                illegal_op !== exp_ill || (mem_read && mem_write)) begin
                if (bad == 0) begin
                    first_act = {state, obs, half, half_unsigned, illegal_op};
                    first_exp = {st[3:0], exp, exp_half, exp_hu, exp_ill};
                end
                bad++;
            end
            if (mem_write) mw_cyc++;
            if (illegal_op) ill_cyc++;
            @(posedge clk);
            cycles++;
            if (st == 1) begin
                exp_half = (op == T_LH) || (op == T_LHU);
                exp_hu   = (op == T_LHU);
            end
            if (!((st == 0 || st == 3 || st == 5) && !mr)) void'(path.pop_front());
            @(negedge clk);
            if (cycles > 200) begin
                bad++;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b0; op_code = T_R;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (mem_read !== 1'b1 || alu_src_b !== 2'b01 || ir_write !== 1'b0)
            begin errors++; $display("FAIL reset_fetch_outputs got mr=%b sb=%b irw=%b exp 1 01 0", mem_read, alu_src_b, ir_write); end
        checks++; if (half !== 1'b0 || half_unsigned !== 1'b0 || illegal_op !== 1'b0)
            begin errors++; $display("FAIL reset_class got half=%b hu=%b ill=%b exp 0 0 0", half, half_unsigned, illegal_op); end
        rst_n = 1'b1;
        exp_half = 1'b0; exp_hu = 1'b0;
    endtask

    task automatic test_lw();
        int cyc, bad, mw, il;
        exec_instr(T_LW, 100, 0, cyc, bad, mw, il);
        checks++; if (bad !== 0) begin errors++; $display("FAIL lw_trace bad=%0d got=%h exp=%h", bad, first_act, first_exp); end
        checks++; if (cyc !== 5) begin errors++; $display("FAIL lw_cycles got=%0d exp=5", cyc); end
    endtask

    task automatic test_lhu();
        int cyc, bad, mw, il;
        exec_instr(T_LHU, 100, 0, cyc, bad, mw, il);
        checks++; if (bad !== 0) begin errors++; $display("FAIL lhu_trace bad=%0d got=%h exp=%h", bad, first_act, first_exp); end
        checks++; if (half !== 1'b1 || half_unsigned !== 1'b1)
            begin errors++; $display("FAIL lhu_class_held got=%b%b exp=11", half, half_unsigned); end
        exec_instr(T_LH, 100, 0, cyc, bad, mw, il);
        checks++; if (bad !== 0) begin errors++; $display("FAIL lh_trace bad=%0d got=%h exp=%h", bad, first_act, first_exp); end
    endtask

    task automatic test_sw_wait();
        int cyc, bad, mw, il;
        exec_instr(T_SW, 100, 3, cyc, bad, mw, il);
        checks++; if (bad !== 0) begin errors++; $display("FAIL sw_wait_trace bad=%0d got=%h exp=%h", bad, first_act, first_exp); end
        checks++; if (mw !== 4) begin errors++; $display("FAIL sw_mem_write_hold got=%0d exp=4", mw); end
        checks++; if (cyc !== 7) begin errors++; $display("FAIL sw_wait_cycles got=%0d exp=7", cyc); end
    endtask

    task automatic test_ori();
        int cyc, bad, mw, il;
        exec_instr(T_ORI, 100, 0, cyc, bad, mw, il);
        checks++; if (bad !== 0) begin errors++; $display("FAIL ori_trace bad=%0d got=%h exp=%h", bad, first_act, first_exp); end
        checks++; if (cyc !== 4) begin errors++; $display("FAIL ori_cycles got=%0d exp=4", cyc); end
    endtask

    task automatic test_illegal();
        int cyc, bad, mw, il;
        exec_instr(6'b111111, 100, 0, cyc, bad, mw, il);
        checks++; if (bad !== 0) begin errors++; $display("FAIL illegal_trace bad=%0d got=%h exp=%h", bad, first_act, first_exp); end
        checks++; if (il !== 1) begin errors++; $display("FAIL illegal_pulse_len got=%0d exp=1", il); end
        checks++; if (cyc !== 2) begin errors++; $display("FAIL illegal_cycles got=%0d exp=2", cyc); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[4];
        int exp_cyc[4];
        int cyc, bad, mw, il;
        ops[0] = T_J; ops[1] = T_R; ops[2] = T_ADDI; ops[3] = T_BEQ;
        exp_cyc[0] = 3; exp_cyc[1] = 4; exp_cyc[2] = 4; exp_cyc[3] = 3;
        for (int i = 0; i < 4; i++) begin
            exec_instr(ops[i], 100, 0, cyc, bad, mw, il);
            checks++; if (bad !== 0 || cyc !== exp_cyc[i])
                begin errors++; $display("FAIL b2b_%0d op=%b bad=%0d cycles got=%0d exp=%0d", i, ops[i], bad, cyc, exp_cyc[i]); end
        end
    endtask

    task automatic test_reset_mid_wait();
        int n, cyc, bad, mw, il;
        op_code = T_LHU; mem_ready = 1'b1; n = 0;
        while (state !== 4'd3 && n < 10) begin
            @(posedge clk); #1; n++;
        end
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (state !== 4'd3 || mem_read !== 1'b1 || i_or_d !== 1'b1 || half !== 1'b1)
            begin errors++; $display("FAIL mid_wait_hold got st=%0d mr=%b iod=%b half=%b exp 3 1 1 1", state, mem_read, i_or_d, half); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (state !== 4'd0 || half !== 1'b0 || half_unsigned !== 1'b0)
            begin errors++; $display("FAIL mid_wait_reset got st=%0d half=%b hu=%b exp 0 0 0", state, half, half_unsigned); end
        checks++; if (mem_read !== 1'b1 || i_or_d !== 1'b0 || reg_write !== 1'b0 || mem_write !== 1'b0)
            begin errors++; $display("FAIL mid_wait_reset_outputs got mr=%b iod=%b rw=%b mw=%b exp 1 0 0 0", mem_read, i_or_d, reg_write, mem_write); end
        rst_n = 1'b1;
        exp_half = 1'b0; exp_hu = 1'b0;
        exec_instr(T_BEQ, 100, 0, cyc, bad, mw, il);
        checks++; if (bad !== 0 || cyc !== 3)
            begin errors++; $display("FAIL post_reset_beq bad=%0d cycles got=%0d exp=3", bad, cyc); end
    endtask

    task automatic test_random();
        logic [5:0] pool[11];
        logic [5:0] op;
        int cyc, bad, mw, il, total_bad;
        pool[0] = T_R; pool[1] = T_LW; pool[2] = T_SW; pool[3] = T_LH; pool[4] = T_LHU;
        pool[5] = T_ADDI; pool[6] = T_ANDI; pool[7] = T_ORI; pool[8] = T_BEQ; pool[9] = T_J;
        pool[10] = 6'b0;
        total_bad = 0;
        for (int i = 0; i < 40; i++) begin
            op = pool[$urandom_range(0, 10)];
            if (op == 6'b0 && $urandom_range(0, 1) == 1) op = 6'($urandom_range(0, 63));
            exec_instr(op, 60, 0, cyc, bad, mw, il);
            if (bad != 0 && total_bad == 0)
                $display("random op=%b first got=%h exp=%h", op, first_act, first_exp);
            total_bad += bad;
        end
        checks++; if (total_bad !== 0) begin errors++; $display("FAIL random_traces bad_cycles got=%0d exp=0", total_bad); end
    endtask

    task automatic test_params();
        logic [5:0] ops[10];
        int sts[10];
        logic ill[10];
        rst_n = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_half = 1'b0; exp_hu = 1'b0;
        ops = '{T_LHU, T_LHU, T_J, T_J, T_LW, T_LW, T_LW, T_LW, T_LW, T_LW};
        sts = '{0, 1, 0, 1, 0, 1, 2, 3, 4, 0};
        ill = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            op_code = ops[i];
            #1;
            checks++; if (state_b !== sts[i][3:0] || illegal_op_b !== ill[i] || ir_write_b !== (sts[i] == 0) || half_b !== 1'b0)
                begin errors++; $display("FAIL param_cycle_%0d got st=%0d ill=%b irw=%b half=%b exp st=%0d ill=%b", i, state_b, illegal_op_b, ir_write_b, half_b, sts[i], ill[i]); end
            @(negedge clk);
        end
        checks++; if (state !== 4'd0 || ir_write !== 1'b0 || mem_read !== 1'b1)
            begin errors++; $display("FAIL fetch_wait_hold got st=%0d irw=%b mr=%b exp 0 0 1", state, ir_write, mem_read); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lhu();
        test_sw_wait();
        test_ori();
        test_illegal();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        test_params();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
